// File: rtl/spi_target_pkg.sv
// Shared types for the SPI target front end.
package spi_target_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StActive   = 2'd1,
    StWaitIdle = 2'd2
  } spi_state_t;

  localparam int unsigned ByteW = 8;
  localparam int unsigned BitCntW = 3;

endpackage

// File: rtl/spi_target_pin_sync.sv
// Multi-stage synchroniser for one asynchronous pin, with registered-edge detection.
module spi_target_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        ResetVal    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   dly_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= {SYNC_STAGES{ResetVal}};
      dly_q   <= ResetVal;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], din};
      dly_q   <= chain_q[SYNC_STAGES-1];
    end
  end

  assign level = chain_q[SYNC_STAGES-1];
  assign rise  = level & ~dly_q;
  assign fall  = ~level & dly_q;

endmodule

// File: rtl/spi_target.sv
// Mode-0 SPI target: synchronises pins, deserialises MOSI bytes, serialises MISO bytes.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [ByteW-1:0] spi_tx_byte,
  output logic             spi_rx_valid,
  output logic [ByteW-1:0] spi_rx_byte,
  output logic             frame_active,
  output logic             frame_abort
);

  localparam int unsigned CntW = $clog2(SYNC_STAGES + 1);

  logic sclk_level_unused, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  spi_target_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .ResetVal   (1'b0)
  ) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sclk),
    .level(sclk_level_unused),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_target_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .ResetVal   (1'b1)
  ) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (cs_n),
    .level(cs_level),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  spi_target_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .ResetVal   (1'b0)
  ) u_mosi_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (mosi),
    .level(mosi_level),
    .rise (mosi_rise_unused),
    .fall (mosi_fall_unused)
  );

  spi_state_t         state_q;
  logic [BitCntW-1:0] bit_cnt_q;
  logic [ByteW-1:0]   tx_shift_q;
  logic [ByteW-1:0]   rx_shift_q;
  logic               byte_done_q;
  logic               armed_q;
  logic [CntW-1:0]    settle_q;

  // After reset the synchronisers hold idle levels; wait until they reflect the
  // real pins before trusting cs_n, so a frame already in progress is never joined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      byte_done_q  <= 1'b0;
      armed_q      <= 1'b0;
      settle_q     <= '0;
      spi_rx_valid <= 1'b0;
      spi_rx_byte  <= '0;
      frame_active <= 1'b0;
      frame_abort  <= 1'b0;
    end else begin
      spi_rx_valid <= byte_done_q;
      byte_done_q  <= 1'b0;
      frame_abort  <= 1'b0;
      if (byte_done_q) begin
        spi_rx_byte <= rx_shift_q;
      end

      unique case (state_q)
        StIdle: begin
          if (!armed_q) begin
            if (settle_q == CntW'(SYNC_STAGES)) begin
              armed_q <= 1'b1;
              if (!cs_level) begin
                state_q <= StWaitIdle;
              end
            end else begin
              settle_q <= settle_q + 1'b1;
            end
          end else if (cs_fall) begin
            state_q      <= StActive;
            tx_shift_q   <= spi_tx_byte;
            bit_cnt_q    <= '0;
            frame_active <= 1'b1;
          end
        end

        StActive: begin
          // A cs_n edge takes priority over any sclk edge in the same cycle.
          if (cs_rise) begin
            state_q      <= StIdle;
            frame_active <= 1'b0;
            frame_abort  <= (bit_cnt_q != '0);
            bit_cnt_q    <= '0;
          end else if (sclk_rise) begin
            rx_shift_q  <= {rx_shift_q[ByteW-2:0], mosi_level};
            bit_cnt_q   <= bit_cnt_q + 1'b1;
            byte_done_q <= (bit_cnt_q == '1);
          end else if (sclk_fall) begin
            if (bit_cnt_q == '0) begin
              tx_shift_q <= spi_tx_byte;
            end else begin
              tx_shift_q <= {tx_shift_q[ByteW-2:0], 1'b0};
            end
          end
        end

        StWaitIdle: begin
          if (cs_level) begin
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign miso    = tx_shift_q[ByteW-1];
  assign miso_oe = frame_active;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: acts as SPI controller plus a handler model, checks against a byte-level model.
module tb_spi_target;

  localparam int unsigned N = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, cs_n, mosi;
  logic       miso, miso_oe;
  logic [7:0] spi_tx_byte;
  logic       spi_rx_valid;
  logic [7:0] spi_rx_byte;
  logic       frame_active, frame_abort;

  always #5 clk = ~clk;

  spi_target #(
    .SYNC_STAGES(N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sclk        (sclk),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .spi_tx_byte (spi_tx_byte),
    .spi_rx_valid(spi_rx_valid),
    .spi_rx_byte (spi_rx_byte),
    .frame_active(frame_active),
    .frame_abort (frame_abort)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] rx_exp_q[$];
  logic [7:0] tx_exp_q[$];
  logic [7:0] last_rx = 8'h00;
  logic [7:0] frame_data[8];
  logic [7:0] miso_got[8];
  int         abort_seen = 0;
  int         valid_seen = 0;
  int         reply_n = 0;
  bit         handler_random = 1'b0;
  bit         reply_pending = 1'b0;
  logic [7:0] reply_val = 8'h00;
  int         half = 8;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Handler model plus per-cycle check of the received-byte stream.
  always @(negedge clk) begin
    if (reply_pending) begin
      spi_tx_byte   = reply_val;
      reply_pending = 1'b0;
    end
    if (rst) begin
      last_rx       = 8'h00;
      reply_pending = 1'b0;
    end else begin
      if (spi_rx_valid) begin
        valid_seen++;
        if (rx_exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rx_unexpected: got valid with byte %0h, expected no valid", spi_rx_byte);
        end else begin
          last_rx = rx_exp_q.pop_front();
          check("rx_byte", spi_rx_byte, last_rx);
        end
        reply_n++;
        reply_val     = handler_random ? 8'($urandom) : 8'(8'h10 + reply_n);
        tx_exp_q.push_back(reply_val);
        reply_pending = 1'b1;
      end else begin
        check("rx_hold", spi_rx_byte, last_rx);
      end
      if (frame_abort) abort_seen++;
    end
  end

  task automatic run_frame(input int nbits, input bit simul, input bit expect_active);
    int         counted;
    logic [7:0] exp0;
    logic [7:0] mbyte;
    logic [7:0] exp_slot;
    bit         last;
    counted = simul ? nbits - 1 : nbits;
    if (expect_active) begin
      for (int i = 0; i < counted / 8; i++) rx_exp_q.push_back(frame_data[i]);
    end
    tx_exp_q.delete();
    reply_n    = 0;
    abort_seen = 0;
    valid_seen = 0;
    exp0       = spi_tx_byte;
    mbyte      = 8'h00;
    @(negedge clk);
    cs_n = 1'b0;
    if (expect_active) begin
      repeat (N) @(negedge clk);
      check("active_early", frame_active, 0);
      @(negedge clk);
      check("frame_active", frame_active, 1);
      check("miso_oe", miso_oe, 1);
    end
    repeat (half) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      last = (b == nbits - 1);
      mosi = frame_data[b / 8][7 - (b % 8)];
      repeat (half) @(negedge clk);
      sclk  = 1'b1;
      mbyte = {mbyte[6:0], miso};
      if (simul && last) cs_n = 1'b1;
      if ((b % 8 == 7) && expect_active && !(simul && last)) begin
        miso_got[b / 8] = mbyte;
        if (b / 8 == 0) begin
          exp_slot = exp0;
        end else if (tx_exp_q.size() == 0) begin
          exp_slot = ~mbyte;
        end else begin
          exp_slot = tx_exp_q.pop_front();
        end
        check("miso_byte", mbyte, exp_slot);
      end
      repeat (half) @(negedge clk);
      sclk = 1'b0;
    end
    if (!simul) begin
      repeat (half) @(negedge clk);
      cs_n = 1'b1;
    end
    repeat (20) @(negedge clk);
    check("rx_drained", rx_exp_q.size(), 0);
    check("abort_count", abort_seen, (expect_active && (counted % 8 != 0)) ? 1 : 0);
    check("active_end", frame_active, 0);
  endtask

  initial begin
    int nb;
    int nbits;
    bit simul;
    rst         = 1'b1;
    sclk        = 1'b0;
    cs_n        = 1'b1;
    mosi        = 1'b0;
    spi_tx_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_valid", spi_rx_valid, 0);
    check("rst_rx_byte", spi_rx_byte, 0);
    check("rst_active", frame_active, 0);
    check("rst_abort", frame_abort, 0);
    #2 rst = 1'b0;
    repeat (N + 4) @(negedge clk);

    // Single byte with preset MISO byte.
    half          = 8;
    frame_data[0] = 8'hA5;
    spi_tx_byte   = 8'h3C;
    run_frame(8, 1'b0, 1'b1);
    check("single_rx", spi_rx_byte, 8'hA5);
    check("single_pulses", valid_seen, 1);
    check("first_miso", miso_got[0], 8'h3C);

    // Back-to-back bytes with handler replies 0x11, 0x12.
    frame_data[0] = 8'h01;
    frame_data[1] = 8'h02;
    frame_data[2] = 8'h03;
    spi_tx_byte   = 8'h77;
    run_frame(24, 1'b0, 1'b1);
    check("b2b_pulses", valid_seen, 3);
    check("b2b_last_rx", spi_rx_byte, 8'h03);
    check("b2b_miso1", miso_got[1], 8'h11);
    check("b2b_miso2", miso_got[2], 8'h12);

    // Abort after 5 bits, then a clean 0xFF frame.
    frame_data[0] = 8'hC3;
    run_frame(5, 1'b0, 1'b1);
    check("abort_no_valid", valid_seen, 0);
    frame_data[0] = 8'hFF;
    run_frame(8, 1'b0, 1'b1);
    check("after_abort_rx", spi_rx_byte, 8'hFF);

    // Reset mid-frame with cs_n held low.
    abort_seen = 0;
    valid_seen = 0;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (half) @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      mosi = b[0];
      repeat (half) @(negedge clk);
      sclk = 1'b1;
      repeat (half) @(negedge clk);
      sclk = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    check("midrst_rx_byte", spi_rx_byte, 0);
    check("midrst_active", frame_active, 0);
    check("midrst_miso_oe", miso_oe, 0);
    check("midrst_miso", miso, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int b = 0; b < 8; b++) begin
      mosi = ~b[0];
      repeat (half) @(negedge clk);
      sclk = 1'b1;
      repeat (half) @(negedge clk);
      sclk = 1'b0;
    end
    check("waitidle_active", frame_active, 0);
    repeat (half) @(negedge clk);
    cs_n = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_no_valid", valid_seen, 0);
    check("midrst_no_abort", abort_seen, 0);
    frame_data[0] = 8'h5A;
    run_frame(8, 1'b0, 1'b1);
    check("after_rst_rx", spi_rx_byte, 8'h5A);

    // cs_n rise coincides with the last sclk rise.
    frame_data[0] = 8'h96;
    run_frame(8, 1'b1, 1'b1);
    check("simul_no_valid", valid_seen, 0);
    check("simul_rx_kept", spi_rx_byte, 8'h5A);

    // Randomised frames with random handler replies.
    handler_random = 1'b1;
    for (int f = 0; f < 20; f++) begin
      nb = int'($urandom_range(1, 4));
      for (int i = 0; i < nb; i++) frame_data[i] = 8'($urandom);
      nbits = nb * 8;
      if ($urandom_range(0, 3) == 0) nbits = nbits - int'($urandom_range(1, 7));
      simul       = ($urandom_range(0, 5) == 0);
      half        = int'($urandom_range(5, 10));
      spi_tx_byte = 8'($urandom);
      run_frame(nbits, simul, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
